// File: rtl/mccomp_loader_if.sv
// mccomp_loader_if: byte-stream handshake and memory write port of the
// program loader. The slave modport is the loader side, the master modport
// is the system side (byte source plus memory).
interface mccomp_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/mccomp_loader.sv
// mccomp_loader: program loader for the multi-cycle computer's unified memory.
// Accepts a byte stream (16-bit LE word count, then that many 32-bit LE words),
// writes the words to consecutive addresses from BASE_ADDR, and holds the CPU
// in reset until the load has completed.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of every
// preceding stream byte (count bytes included) must follow the last word;
// a mismatch ends the load in ERR with the CPU still held in reset.
// ADDR_W is expected to be at most 16 (the count field is 16 bits wide).
module mccomp_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  mccomp_loader_if.slave        bus,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
  // Memory depth as a 17-bit value so that 2^16 is representable.
  localparam logic [16:0]       LP_DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK    = 3'd5,
`endif
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_rstn;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_words_loaded;
  logic [15:0]       r_count;
  logic [1:0]        r_idx;

  logic              w_xfer;
  logic              w_start_ok;
  logic [15:0]       w_count_full;
  logic [15:0]       w_words_inc;
  logic              w_in_ready_nxt;
  logic              w_mem_we_nxt;
  logic              w_cpu_rstn_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  assign w_xfer       = bus.in_valid & r_in_ready;
  assign w_start_ok   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
  // Full count as it will be once the high byte currently on the bus is latched.
  assign w_count_full = {bus.in_data, r_count[7:0]};
  assign w_words_inc  = r_words_loaded + 16'd1;

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign cpu_rstn      = r_cpu_rstn;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_loaded  = r_words_loaded;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: walks the stream format, one transfer per state step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CNT_LO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CNT_LO: begin
        if (w_xfer) begin
          w_state_nxt = ST_CNT_HI;
        end else begin
          w_state_nxt = ST_CNT_LO;
        end
      end
      ST_CNT_HI: begin
        if (w_xfer) begin
          if (w_count_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_nxt = ST_CHK;
`else
            w_state_nxt = ST_DONE;
`endif
          end else if ({1'b0, w_count_full} > LP_DEPTH) begin
            w_state_nxt = ST_ERR;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_CNT_HI;
        end
      end
      ST_DATA: begin
        if (w_xfer && (r_idx == 2'd3)) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_WRITE: begin
        if (w_words_inc == r_count) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = ST_CHK;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_xfer) begin
          if (bus.in_data == r_csum) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end else begin
          w_state_nxt = ST_CHK;
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nxt = ST_CNT_LO;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered flags line up with it.
  always_comb begin
    w_in_ready_nxt = 1'b0;
    w_mem_we_nxt   = 1'b0;
    w_cpu_rstn_nxt = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    case (w_state_nxt)
      ST_CNT_LO, ST_CNT_HI, ST_DATA: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      ST_WRITE: begin
        w_mem_we_nxt   = 1'b1;
        w_busy_nxt     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
`endif
      ST_DONE: begin
        w_done_nxt     = 1'b1;
        w_cpu_rstn_nxt = 1'b1;
      end
      ST_ERR: begin
        w_err_nxt      = 1'b1;
      end
      default: begin
        w_in_ready_nxt = 1'b0;
      end
    endcase
  end

  // Registered handshake, write strobe and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cpu_rstn <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_cpu_rstn <= w_cpu_rstn_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Datapath: count capture, word assembly, address and word counter update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count        <= 16'h0000;
      r_idx          <= 2'd0;
      r_mem_addr     <= LP_BASE;
      r_mem_wdata    <= 32'h0000_0000;
      r_words_loaded <= 16'h0000;
    end else if (w_start_ok) begin
      r_words_loaded <= 16'h0000;
      r_mem_addr     <= LP_BASE;
      r_idx          <= 2'd0;
    end else begin
      case (r_state)
        ST_CNT_LO: begin
          if (w_xfer) begin
            r_count[7:0] <= bus.in_data;
          end
        end
        ST_CNT_HI: begin
          if (w_xfer) begin
            r_count[15:8] <= bus.in_data;
            r_idx         <= 2'd0;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_mem_wdata[{r_idx, 3'b000} +: 8] <= bus.in_data;
            r_idx                             <= r_idx + 2'd1;
          end
        end
        ST_WRITE: begin
          r_words_loaded <= w_words_inc;
          r_mem_addr     <= r_mem_addr + ADDR_W'(1);
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every count and data byte of the current load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_csum <= 8'h00;
    end else if (w_start_ok) begin
      r_csum <= 8'h00;
    end else if (w_xfer && ((r_state == ST_CNT_LO) || (r_state == ST_CNT_HI) || (r_state == ST_DATA))) begin
      r_csum <= r_csum ^ bus.in_data;
    end
  end
`endif

endmodule

// File: doc/mccomp_loader.md
Name: mccomp_loader

Overview:
- Hardware program loader for the multi-cycle computer's unified instruction/data memory; replaces simulation-only memory preloading.
- Receives a byte stream, assembles 32-bit little-endian words and writes them to consecutive word addresses.
- Holds the CPU in reset while loading and releases it when the load completes.
- Sits between an external byte source (UART RX or bench) and the memory write port and CPU reset input.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- cpu_rstn  output  1  active-low reset to the CPU core.
- busy  output  1  high in CNT_LO, CNT_HI, DATA, WRITE (and CHK when enabled).
- done  output  1  high in DONE.
- err  output  1  high in ERR.
- words_loaded  output  16  count of words written in the current or last load.

Behaviour:
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_rstn 0, busy 0, done 0, err 0, words_loaded 0.
- Handshake: a byte transfers when in_valid && in_ready at a rising edge. in_ready is a registered function of state.
  - in_ready is 1 in CNT_LO, CNT_HI, DATA and CHK.
  - in_ready is 0 in every other state.
- Stream format: count N (16-bit little-endian: low byte, then high byte), then N words of 4 bytes each, least significant byte first.
- States:
  - IDLE: cpu_rstn 0. On start, go to CNT_LO, clear words_loaded, set mem_addr to BASE_ADDR.
  - CNT_LO: on a transfer, latch N[7:0] and go to CNT_HI.
  - CNT_HI: on a transfer, latch N[15:8].
    - If N == 0, go to DONE.
    - If N > 2^ADDR_W, go to ERR.
    - Otherwise go to DATA with byte index 0.
  - DATA: each transfer shifts the byte into mem_wdata[8*idx +: 8] and increments idx. The 4th byte goes to WRITE.
  - WRITE: exactly one cycle.
    - mem_we = 1, with mem_addr and mem_wdata stable.
    - Next cycle: words_loaded += 1 and mem_addr += 1, wrapping modulo 2^ADDR_W.
    - If words_loaded reaches N, go to DONE (or CHK when enabled); otherwise go to DATA.
  - DONE: done = 1. cpu_rstn goes high on the first DONE cycle (registered) and stays high.
  - ERR: err = 1, cpu_rstn stays 0, nothing more is written.
- A start in DONE or ERR restarts the load.
  - cpu_rstn drops to 0 on the cycle after start.
  - done and err clear on that same cycle.
- A start while busy is ignored.
- A byte offered while in_ready = 0 is not consumed; the source must hold it.
- Asynchronous reset at any point aborts the load immediately. All outputs go to their reset values, and a partially assembled word is discarded and never written.
- Load latency from the last data byte to mem_we is 1 cycle. Throughput is at most 1 word per 5 cycles.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CHK and accept one byte.
  - Compare it with the running XOR of every stream byte, count bytes included.
  - Match goes to DONE; mismatch goes to ERR with cpu_rstn held at 0.
  - For N == 0, CNT_HI goes to CHK.
- Not defined: no CHK state and no trailing byte; behaviour is exactly as above.

Test Plan:
- Reset, start, stream 02 00 78 56 34 12 EF BE AD DE
  -> mem_we pulses at addr 0 (wdata 0x12345678) and addr 1 (wdata 0xDEADBEEF); done = 1; cpu_rstn 0 -> 1; words_loaded = 2.
- Stream 00 00 -> no mem_we, done = 1, cpu_rstn = 1.
- Count 01 01 (257) with ADDR_W = 8 -> err = 1, in_ready = 0, no writes, cpu_rstn = 0.
- in_valid toggled randomly during a 3-word load -> identical writes and addresses as a back-to-back stream; in_ready = 0 during WRITE.
- Assert rstn low after 2 data bytes of word 1 -> all outputs at reset values; the following start and a full stream load correctly from BASE_ADDR.
- With LOADER_CHECKSUM_EN: stream 01 00 11 22 33 44 + checksum 0x45 -> done. Same stream with checksum 0x46 -> err, cpu_rstn = 0.
